// File: rtl/mem_mon_pkg.sv
// Shared types and constants for the memory checking monitor.
package mem_mon_pkg;

  localparam int MON_DATA_WIDTH = 8;
  localparam int MON_ADDR_WIDTH = 8;
  localparam int MON_CNT_WIDTH  = 16;

  localparam logic [MON_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [MON_ADDR_WIDTH-1:0] addr;
    logic [MON_DATA_WIDTH-1:0] exp;
    logic [MON_DATA_WIDTH-1:0] act;
  } err_rec_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ
  } op_e;

endpackage

// File: rtl/mem_mon_err_fifo.sv
// Mismatch record FIFO: head is visible combinationally; a push into a full
// FIFO without a same-cycle pop is dropped and latches a sticky overflow flag.
module mem_mon_err_fifo
  import mem_mon_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rec_t = err_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_rec,
  input  logic pop,
  output rec_t head,
  output logic empty,
  output logic full,
  output logic overflow
);

  localparam int PW = $clog2(DEPTH);

  rec_t          mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/mem_check_monitor.sv
// Passive checker for a single-port memory: shadows writes, compares read
// returns against the value captured at issue, and keeps usage statistics.
module mem_check_monitor
  import mem_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16,
  parameter int ERR_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_err_pop,
  output logic                  o_err_valid,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  output logic [DATA_WIDTH-1:0] o_err_exp,
  output logic [DATA_WIDTH-1:0] o_err_act,
  output logic                  o_err_overflow,
  output logic [CNT_WIDTH-1:0]  o_wr_count,
  output logic [CNT_WIDTH-1:0]  o_rd_count,
  output logic [CNT_WIDTH-1:0]  o_idle_count,
  output logic [CNT_WIDTH-1:0]  o_mismatch_count
);

  localparam int WORDS = 2 ** ADDR_WIDTH;
  localparam int LAST  = RD_LATENCY - 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] exp;
    logic [DATA_WIDTH-1:0] act;
  } rec_t;

  logic [DATA_WIDTH-1:0] shadow [WORDS];
  logic [WORDS-1:0]      known;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_known;
  logic [ADDR_WIDTH-1:0] pipe_addr [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_exp  [RD_LATENCY];

  op_e  op;
  logic mismatch;
  logic fifo_empty;
  logic fifo_full;
  rec_t push_rec;
  rec_t head_rec;

  always_comb begin
    op = OP_IDLE;
    if (i_wr_en)      op = OP_WRITE;
    else if (i_rd_en) op = OP_READ;
  end

  assign mismatch = pipe_vld[LAST] && pipe_known[LAST] && (i_rd_data != pipe_exp[LAST]);
  assign push_rec = '{addr: pipe_addr[LAST], exp: pipe_exp[LAST], act: i_rd_data};

  // shadow data is deliberately left out of reset; known[] gates its use
  always_ff @(posedge i_clk) begin
    if (op == OP_WRITE) shadow[i_address] <= i_wr_data;
    pipe_addr[0] <= i_address;
    pipe_exp[0]  <= shadow[i_address];
    for (int i = LAST; i > 0; i--) begin
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_exp[i]  <= pipe_exp[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      known      <= '0;
      pipe_vld   <= '0;
      pipe_known <= '0;
    end else begin
      if (op == OP_WRITE) known[i_address] <= 1'b1;
      pipe_vld[0]   <= (op == OP_READ);
      pipe_known[0] <= known[i_address];
      for (int i = LAST; i > 0; i--) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_known[i] <= pipe_known[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_count       <= '0;
      o_rd_count       <= '0;
      o_idle_count     <= '0;
      o_mismatch_count <= '0;
    end else begin
      unique case (op)
        OP_WRITE: if (!(&o_wr_count))   o_wr_count   <= o_wr_count + 1'b1;
        OP_READ:  if (!(&o_rd_count))   o_rd_count   <= o_rd_count + 1'b1;
        default:  if (!(&o_idle_count)) o_idle_count <= o_idle_count + 1'b1;
      endcase
      if (mismatch && !(&o_mismatch_count)) o_mismatch_count <= o_mismatch_count + 1'b1;
    end
  end

  mem_mon_err_fifo #(
    .DEPTH (ERR_DEPTH),
    .rec_t (rec_t)
  ) u_err_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (mismatch),
    .push_rec (push_rec),
    .pop      (i_err_pop),
    .head     (head_rec),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (o_err_overflow)
  );

  assign o_err_valid = !fifo_empty;
  assign o_err_addr  = head_rec.addr;
  assign o_err_exp   = head_rec.exp;
  assign o_err_act   = head_rec.act;

endmodule

// File: tb/tb_mem_check_monitor.sv
// Directed bench for mem_check_monitor with a cycle model and an error-record scoreboard.
module tb_mem_check_monitor;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, err_pop;
  logic [7:0] address, wr_data, rd_data;

  logic        e1_valid, e1_ovf;
  logic [7:0]  e1_addr, e1_exp, e1_act;
  logic [15:0] c1_wr, c1_rd, c1_idle, c1_mm;

  logic        e3_valid, e3_ovf;
  logic [7:0]  e3_addr, e3_exp, e3_act;
  logic [3:0]  c3_wr, c3_rd, c3_idle, c3_mm;

  always #5 clk = ~clk;

  mem_check_monitor u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_address(address), .i_wr_data(wr_data), .i_rd_data(rd_data), .i_err_pop(err_pop),
    .o_err_valid(e1_valid), .o_err_addr(e1_addr), .o_err_exp(e1_exp), .o_err_act(e1_act),
    .o_err_overflow(e1_ovf), .o_wr_count(c1_wr), .o_rd_count(c1_rd),
    .o_idle_count(c1_idle), .o_mismatch_count(c1_mm)
  );

  mem_check_monitor #(.RD_LATENCY(3), .CNT_WIDTH(4)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_address(address), .i_wr_data(wr_data), .i_rd_data(rd_data), .i_err_pop(err_pop),
    .o_err_valid(e3_valid), .o_err_addr(e3_addr), .o_err_exp(e3_exp), .o_err_act(e3_act),
    .o_err_overflow(e3_ovf), .o_wr_count(c3_wr), .o_rd_count(c3_rd),
    .o_idle_count(c3_idle), .o_mismatch_count(c3_mm)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] e;
    logic [7:0] x;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int         m_wr, m_rd, m_idle, m_mm;
  bit         m_ovf;
  logic [7:0] sh_m [256];
  bit         kn_m [256];
  bit         pend_v, pend_k;
  logic [7:0] pend_a, pend_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock with the given bus values; the model advances at the same edge
  task automatic step(input bit r, input bit w, input bit rd, input bit p,
                      input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rdat);
    rec_t tmp;
    rst = r; wr_en = w; rd_en = rd; err_pop = p;
    address = a; wr_data = wd; rd_data = rdat;
    @(posedge clk);
    if (r) begin
      m_wr = 0; m_rd = 0; m_idle = 0; m_mm = 0; m_ovf = 0;
      exp_q.delete();
      for (int i = 0; i < 256; i++) kn_m[i] = 0;
      pend_v = 0;
    end else begin
      if (p && exp_q.size() > 0) tmp = exp_q.pop_front();
      if (pend_v && pend_k && rdat !== pend_e) begin
        m_mm++;
        if (exp_q.size() < 4) exp_q.push_back('{a: pend_a, e: pend_e, x: rdat});
        else m_ovf = 1;
      end
      pend_v = 0;
      if (w) begin
        m_wr++; sh_m[a] = wd; kn_m[a] = 1;
      end else if (rd) begin
        m_rd++; pend_v = 1; pend_a = a; pend_k = kn_m[a]; pend_e = sh_m[a];
      end else begin
        m_idle++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] rdat);
    step(0, 0, 0, 0, 8'h00, 8'h00, rdat);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wr"},   32'(c1_wr),   32'(m_wr));
    check({tag, ".rd"},   32'(c1_rd),   32'(m_rd));
    check({tag, ".idle"}, 32'(c1_idle), 32'(m_idle));
    check({tag, ".mm"},   32'(c1_mm),   32'(m_mm));
    check({tag, ".ovf"},  32'(e1_ovf),  32'(m_ovf));
    check({tag, ".valid"}, 32'(e1_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check({tag, ".addr"}, 32'(e1_addr), 32'(exp_q[0].a));
      check({tag, ".exp"},  32'(e1_exp),  32'(exp_q[0].e));
      check({tag, ".act"},  32'(e1_act),  32'(exp_q[0].x));
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      step(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
      check_all(tag);
    end
    check({tag, ".empty"}, 32'(e1_valid), 32'd0);
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; err_pop = 0;
    address = 0; wr_data = 0; rd_data = 0;
    for (int i = 0; i < 256; i++) sh_m[i] = 8'h00;
    m_wr = 0; m_rd = 0; m_idle = 0; m_mm = 0; m_ovf = 0; pend_v = 0; pend_k = 0;
    pend_a = 0; pend_e = 0;

    // 1: reset then idle
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check_all("rst");
    repeat (5) idle(8'h00);
    check_all("t1");
    check("t1.idle5", 32'(c1_idle), 32'd5);

    // 2: clean write/read
    step(0, 1, 0, 0, 8'h10, 8'h3C, 8'h00);
    step(0, 0, 1, 0, 8'h10, 8'h00, 8'h00);
    idle(8'h3C);
    check_all("t2");
    check("t2.wr1", 32'(c1_wr), 32'd1);
    check("t2.rd1", 32'(c1_rd), 32'd1);

    // 3: single forced mismatch
    step(0, 1, 0, 0, 8'h01, 8'hA5, 8'h00);
    step(0, 0, 1, 0, 8'h01, 8'h00, 8'h00);
    idle(8'h5A);
    check_all("t3");
    check("t3.addr", 32'(e1_addr), 32'h01);
    check("t3.exp",  32'(e1_exp),  32'hA5);
    check("t3.act",  32'(e1_act),  32'h5A);
    check("t3.mm",   32'(c1_mm),   32'd1);
    drain("t3.pop");
    step(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    check_all("t3.emptypop");

    // 4: overflow with back-to-back reads
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(8'h40 + i), 8'(8'h80 + i), 8'h00);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 0, 8'(8'h40 + i), 8'h00, (i == 0) ? 8'h00 : 8'(~(8'h80 + i - 1)));
    idle(8'(~8'h84));
    check_all("t4");
    check("t4.ovf", 32'(e1_ovf), 32'd1);
    check("t4.mm5", 32'(c1_mm),  32'd5);
    drain("t4.pop");

    // 4b: push and pop in the same cycle while full does not drop
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(8'h50 + i), 8'(8'h60 + i), 8'h00);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 0, 8'(8'h50 + i), 8'h00, (i == 0) ? 8'h00 : 8'(8'h60 + i + 7));
    step(0, 0, 0, 1, 8'h00, 8'h00, 8'h6C);
    check_all("t4b");
    check("t4b.ovf", 32'(e1_ovf), 32'd0);
    drain("t4b.pop");

    // 5: write wins over read; unknown address is never compared
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(0, 1, 1, 0, 8'h20, 8'h77, 8'h00);
    idle(8'h00);
    check_all("t5a");
    check("t5a.rd0", 32'(c1_rd), 32'd0);
    step(0, 0, 1, 0, 8'h7F, 8'h00, 8'h00);
    idle(8'hEE);
    check_all("t5b");
    check("t5b.valid", 32'(e1_valid), 32'd0);

    // 6: reset discards in-flight reads; 4-bit counters saturate
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(0, 1, 0, 0, 8'h05, 8'h11, 8'h00);
    step(0, 0, 1, 0, 8'h05, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h22);
    check("t6.wr0",   32'(c3_wr),   32'd0);
    check("t6.rd0",   32'(c3_rd),   32'd0);
    check("t6.idle0", 32'(c3_idle), 32'd0);
    check("t6.mm0",   32'(c3_mm),   32'd0);
    repeat (4) idle(8'h22);
    check("t6.valid", 32'(e3_valid), 32'd0);
    check("t6.mm",    32'(c3_mm),    32'd0);
    repeat (16) idle(8'h22);
    check("t6.sat", 32'(c3_idle), 32'd15);
    check_all("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
